// File: rtl/baud_config_ctrl.sv
// -----------------------------------------------------------------------------
// baud_config_ctrl
//   Changes the UART baud rate at run time without glitching a frame. A single
//   requester hands over a baud index over a valid/ready handshake. The
//   controller waits until TX and RX have both been idle for GUARD_CYCLES
//   consecutive cycles. It then loads the new divisor into the baud-rate
//   generator and pulses the generator reset for one cycle.
//
//   Optional feature: define BAUD_CFG_TIMEOUT_EN to bound the idle wait to
//   TIMEOUT_CYCLES cycles. On expiry the controller pulses o_cfg_err and drops
//   the request. Without the macro the wait is unbounded and o_cfg_err is 0.
//
// Ports
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_cfg_valid  configuration request
//   i_cfg_sel    baud index 0..7 = 1200,2400,4800,9600,19200,38400,57600,115200
//   o_cfg_ready  high only while IDLE
//   i_tx_busy    transmitter frame in progress
//   i_rx_busy    receiver frame in progress
//   o_div        registered divisor to the baud generator
//   o_gen_reset  one-cycle generator reset, high during APPLY
//   o_cfg_done   one-cycle pulse after a successful apply
//   o_cfg_err    one-cycle pulse on idle-wait timeout (macro builds only)
//   o_cur_sel    registered, currently applied baud index
// -----------------------------------------------------------------------------
module baud_config_ctrl #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int NB_DIV         = 16,
  parameter int DEFAULT_SEL    = 7,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int NB_TIMEOUT     = 24
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_cfg_valid,
  input  logic [2:0]        i_cfg_sel,
  output logic              o_cfg_ready,
  input  logic              i_tx_busy,
  input  logic              i_rx_busy,
  output logic [NB_DIV-1:0] o_div,
  output logic              o_gen_reset,
  output logic              o_cfg_done,
  output logic              o_cfg_err,
  output logic [2:0]        o_cur_sel
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  // Divisor for one baud rate. Integer truncation, then clamped so that the
  // generator never sees 0 and the value always fits in NB_DIV bits.
  function automatic logic [NB_DIV-1:0] calc_div(input longint baud);
    longint q;
    longint max_div;
    max_div = (longint'(1) << NB_DIV) - 1;
    q       = longint'(CLK_FREQ) / (baud * 16) - 1;
    if (q < 1)       q = 1;
    if (q > max_div) q = max_div;
    return NB_DIV'(q);
  endfunction

  localparam logic [NB_DIV-1:0] DIV0 = calc_div(1200);
  localparam logic [NB_DIV-1:0] DIV1 = calc_div(2400);
  localparam logic [NB_DIV-1:0] DIV2 = calc_div(4800);
  localparam logic [NB_DIV-1:0] DIV3 = calc_div(9600);
  localparam logic [NB_DIV-1:0] DIV4 = calc_div(19200);
  localparam logic [NB_DIV-1:0] DIV5 = calc_div(38400);
  localparam logic [NB_DIV-1:0] DIV6 = calc_div(57600);
  localparam logic [NB_DIV-1:0] DIV7 = calc_div(115200);

  // Constant table lookup; reduces to an 8-way mux of constants.
  function automatic logic [NB_DIV-1:0] div_of(input logic [2:0] sel);
    logic [NB_DIV-1:0] d;
    case (sel)
      3'd0:    d = DIV0;
      3'd1:    d = DIV1;
      3'd2:    d = DIV2;
      3'd3:    d = DIV3;
      3'd4:    d = DIV4;
      3'd5:    d = DIV5;
      3'd6:    d = DIV6;
      default: d = DIV7;
    endcase
    return d;
  endfunction

  localparam logic [2:0] DEF_SEL = 3'(DEFAULT_SEL);

`ifdef BAUD_CFG_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_APPLY, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_APPLY, S_DONE
  } state_t;
`endif

  state_t          state;
  logic [GW-1:0]   guard_cnt;
  logic [2:0]      sel_lat;
  logic            line_busy;

  assign line_busy = i_tx_busy | i_rx_busy;

`ifdef BAUD_CFG_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] tmo_cnt;
  logic                  tmo_hit;

  // The counter holds k-1 on the k-th WAIT_IDLE edge, so a hit here means
  // WAIT_IDLE has already lasted TIMEOUT_CYCLES cycles.
  assign tmo_hit = (tmo_cnt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ((TIMEOUT_CYCLES + NB_TIMEOUT) != 0);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_IDLE;
      o_cfg_ready <= 1'b1;
      o_div       <= div_of(DEF_SEL);
      o_cur_sel   <= DEF_SEL;
      o_gen_reset <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
      guard_cnt   <= '0;
`ifdef BAUD_CFG_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      // Status outputs are single-cycle pulses by default.
      o_gen_reset <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;

      case (state)
        S_IDLE: begin
          guard_cnt <= '0;
`ifdef BAUD_CFG_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          if (i_cfg_valid && o_cfg_ready) begin
            sel_lat     <= i_cfg_sel;
            o_cfg_ready <= 1'b0;
            state       <= S_WAIT_IDLE;
          end
        end

        S_WAIT_IDLE: begin
`ifdef BAUD_CFG_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (!line_busy && guard_cnt == GW'(GUARD_CYCLES - 1)) begin
            // Divisor and index load on the edge into APPLY so both are
            // already valid while the generator reset is asserted.
            o_div       <= div_of(sel_lat);
            o_cur_sel   <= sel_lat;
            o_gen_reset <= 1'b1;
            state       <= S_APPLY;
          end else begin
            if (line_busy) guard_cnt <= '0;
            else           guard_cnt <= guard_cnt + 1'b1;
`ifdef BAUD_CFG_TIMEOUT_EN
            // Only reached when APPLY was not taken, so APPLY wins a tie.
            if (tmo_hit) begin
              o_cfg_err <= 1'b1;
              state     <= S_ERR;
            end
`endif
          end
        end

        S_APPLY: begin
          o_cfg_done <= 1'b1;
          state      <= S_DONE;
        end

        S_DONE: begin
          o_cfg_ready <= 1'b1;
          state       <= S_IDLE;
        end

`ifdef BAUD_CFG_TIMEOUT_EN
        S_ERR: begin
          o_cfg_ready <= 1'b1;
          state       <= S_IDLE;
        end
`endif

        default: begin
          o_cfg_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_config_ctrl.sv
module tb_baud_config_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [2:0]  cfg_sel;
  logic        cfg_ready;
  logic        tx_busy;
  logic        rx_busy;
  logic [15:0] div;
  logic        gen_reset;
  logic        cfg_done;
  logic        cfg_err;
  logic [2:0]  cur_sel;

  int errors = 0;
  int checks = 0;

  baud_config_ctrl #(
    .CLK_FREQ       (50_000_000),
    .NB_DIV         (16),
    .DEFAULT_SEL    (7),
    .GUARD_CYCLES   (4),
    .TIMEOUT_CYCLES (64),
    .NB_TIMEOUT     (24)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_cfg_valid (cfg_valid),
    .i_cfg_sel   (cfg_sel),
    .o_cfg_ready (cfg_ready),
    .i_tx_busy   (tx_busy),
    .i_rx_busy   (rx_busy),
    .o_div       (div),
    .o_gen_reset (gen_reset),
    .o_cfg_done  (cfg_done),
    .o_cfg_err   (cfg_err),
    .o_cur_sel   (cur_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] exp_div;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge where
  // outputs are sampled and inputs are changed.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full transaction with busy low: accept edge e0, APPLY after e4,
  // DONE after e5, ready after e6.
  task automatic run_txn(input logic [2:0] sel, input logic [15:0] exp_div,
                         input logic [15:0] prev_div);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    step();
    cfg_valid = 1'b0;
    chk("ready_low_after_accept", cfg_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_no_gen_reset", gen_reset, 0);
      chk("wait_div_held", div, prev_div);
    end
    step();
    chk("apply_gen_reset", gen_reset, 1);
    chk("apply_div", div, exp_div);
    chk("apply_cur_sel", cur_sel, sel);
    chk("apply_no_done", cfg_done, 0);
    step();
    chk("done_pulse", cfg_done, 1);
    chk("done_gen_reset_low", gen_reset, 0);
    chk("done_ready_low", cfg_ready, 0);
    step();
    chk("ready_back", cfg_ready, 1);
    chk("done_cleared", cfg_done, 0);
    chk("final_div", div, exp_div);
  endtask

  initial begin
    logic [15:0] prev_div;
    int          seen;
    int          never_2603;

    vecs[0] = '{3'd3, 16'd324};
    vecs[1] = '{3'd0, 16'd2603};
    vecs[2] = '{3'd1, 16'd1301};
    vecs[3] = '{3'd2, 16'd650};
    vecs[4] = '{3'd4, 16'd161};
    vecs[5] = '{3'd5, 16'd80};
    vecs[6] = '{3'd6, 16'd53};
    vecs[7] = '{3'd7, 16'd26};

    rst = 1'b1; cfg_valid = 1'b0; cfg_sel = 3'd0; tx_busy = 1'b0; rx_busy = 1'b0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("reset_div", div, 26);
    chk("reset_cur_sel", cur_sel, 7);
    chk("reset_ready", cfg_ready, 1);
    chk("reset_gen_reset", gen_reset, 0);
    chk("reset_done", cfg_done, 0);
    chk("reset_err", cfg_err, 0);

    // Every baud index, including re-applying the current one (sel 7 last)
    prev_div = 16'd26;
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].sel, vecs[i].exp_div, prev_div);
      prev_div = vecs[i].exp_div;
    end

    // Busy with a short glitch: APPLY comes 4 idle cycles after the final fall
    tx_busy = 1'b1;
    cfg_valid = 1'b1; cfg_sel = 3'd3;
    step();
    cfg_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin step(); if (gen_reset) seen = 1; end
    tx_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); if (gen_reset) seen = 1; end
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (gen_reset) seen = 1; end
    chk("glitch_no_early_apply", seen, 0);
    chk("glitch_div_held", div, 26);
    tx_busy = 1'b0;
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      step();
      if (gen_reset) seen = i;
    end
    chk("glitch_apply_delay", seen, 4);
    chk("glitch_div", div, 324);
    step(); step();
    chk("glitch_ready", cfg_ready, 1);

    // Valid while busy is ignored; only the first request is applied
    never_2603 = 1;
    tx_busy = 1'b1;
    cfg_valid = 1'b1; cfg_sel = 3'd5;
    step();
    cfg_sel = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (div == 16'd2603) never_2603 = 0;
    end
    chk("ignored_ready_low", cfg_ready, 0);
    cfg_valid = 1'b0;
    tx_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (div == 16'd2603) never_2603 = 0;
    end
    chk("ignored_never_2603", never_2603, 1);
    chk("ignored_div", div, 80);
    chk("ignored_cur_sel", cur_sel, 5);

    // Reset during WAIT_IDLE abandons the request
    cfg_valid = 1'b1; cfg_sel = 3'd0;
    step();
    cfg_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_div", div, 26);
    chk("midreset_ready", cfg_ready, 1);
    chk("midreset_cur_sel", cur_sel, 7);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cfg_done || gen_reset) seen = 1;
    end
    chk("midreset_no_done", seen, 0);
    chk("midreset_div_after", div, 26);

    // rx_busy stuck high
    rx_busy = 1'b1;
    cfg_valid = 1'b1; cfg_sel = 3'd3;
    step();
    cfg_valid = 1'b0;
`ifdef BAUD_CFG_TIMEOUT_EN
    seen = 0;
    for (int i = 1; i <= 80 && seen == 0; i++) begin
      step();
      if (cfg_err) seen = i;
      if (gen_reset) seen = -1;
    end
    chk("timeout_err_edge", seen, 64);
    chk("timeout_div", div, 26);
    chk("timeout_cur_sel", cur_sel, 7);
    step();
    chk("timeout_err_cleared", cfg_err, 0);
    chk("timeout_ready", cfg_ready, 1);
    rx_busy = 1'b0;
`else
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (cfg_err || gen_reset) seen = 1;
    end
    chk("stuck_no_err_no_apply", seen, 0);
    chk("stuck_ready_low", cfg_ready, 0);
    rx_busy = 1'b0;
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      step();
      if (gen_reset) seen = i;
    end
    chk("stuck_release_apply", seen, 4);
    chk("stuck_release_div", div, 324);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
